// File: rtl/q_ringdown_meter_if.sv
// q_ringdown_meter_if: groups the measurement request, the resonator
// comparator inputs and the result outputs of q_ringdown_meter.
//   master : sweep/stimulus side (drives start, osc_in, env_above)
//   slave  : the meter itself (drives excite, busy, ready, q_measured, timeout)
// WIDTH must equal the WIDTH of the connected meter.
interface q_ringdown_meter_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             osc_in;
  logic             env_above;
  logic             excite;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] q_measured;
  logic             timeout;

  modport master (
    output start, osc_in, env_above,
    input  excite, busy, ready, q_measured, timeout
  );

  modport slave (
    input  start, osc_in, env_above,
    output excite, busy, ready, q_measured, timeout
  );
endinterface

// File: rtl/q_ringdown_meter.sv
// q_ringdown_meter: measures resonator Q by ring-down counting. The resonator
// is driven for EXCITE_CYCLES, released for SETTLE_CYCLES, then rising edges of
// the oscillation comparator are counted while the envelope comparator stays
// high (bounded by TIMEOUT_CYCLES). The count is reported with a ready strobe.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   bus.start      in   measurement request, sampled only in IDLE
//   bus.osc_in     in   asynchronous oscillation comparator
//   bus.env_above  in   asynchronous envelope comparator
//   bus.excite     out  resonator drive enable
//   bus.busy       out  high in every state except IDLE
//   bus.ready      out  one-cycle strobe, result valid from this cycle
//   bus.q_measured out  saturating period count, held until next ready
//   bus.timeout    out  last measurement ended on timeout
//
// Optional feature macro: Q_MEAS_AVG4_EN -- each start runs four ring-downs and
// reports the truncated average of the four saturated counts; timeout is the
// OR over the four runs.
module q_ringdown_meter #(
  parameter int WIDTH          = 10,
  parameter int EXCITE_CYCLES  = 64,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst,
  q_ringdown_meter_if.slave bus
);

  localparam int ES_MAX  = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
  localparam int CYC_MAX = (ES_MAX > TIMEOUT_CYCLES) ? ES_MAX : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CYC_MAX + 1);

  localparam logic [CW-1:0] E_LAST = CW'(EXCITE_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EXCITE, SETTLE, COUNT, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cyc, cyc_n;
  logic [WIDTH-1:0] cnt, cnt_fin, cnt_n;
  logic             run_end, run_tout;
  logic             last_run;
  logic [WIDTH-1:0] result;
  logic             tout_total;
  logic [WIDTH-1:0] q_r;
  logic             tout_r;

  logic osc_p0, osc_p1, osc_p2;
  logic env_p0, env_p1;
  logic rise;

  // Counter never wraps: it sticks at all-ones.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // osc_p1 / env_p1 are the synchronised osc_s / env_s; osc_p2 is the
  // previous osc_s used for rising-edge detection.
  assign rise = osc_p1 & ~osc_p2;

`ifdef Q_MEAS_AVG4_EN
  logic [1:0]       run;
  logic [WIDTH+1:0] sum, sum_n;
  logic             tout_acc;

  assign last_run   = (run == 2'd3);
  assign sum_n      = sum + {2'b00, cnt_fin};
  assign result     = sum_n[WIDTH+1:2];
  assign tout_total = tout_acc | run_tout;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) run <= 2'd0;
    else if (run_end)         run <= run + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      sum      <= '0;
      tout_acc <= 1'b0;
    end else if (run_end) begin
      sum      <= sum_n;
      tout_acc <= tout_acc | run_tout;
    end
  end
`else
  assign last_run   = 1'b1;
  assign result     = cnt_fin;
  assign tout_total = run_tout;
`endif

  always_comb begin
    state_n  = state;
    cyc_n    = cyc + 1'b1;
    cnt_fin  = cnt;
    run_end  = 1'b0;
    run_tout = 1'b0;
    unique case (state)
      IDLE: begin
        cyc_n = '0;
        if (bus.start) state_n = EXCITE;
      end
      EXCITE: begin
        if (cyc == E_LAST) begin
          state_n = SETTLE;
          cyc_n   = '0;
        end
      end
      SETTLE: begin
        if (cyc == S_LAST) begin
          state_n = COUNT;
          cyc_n   = '0;
        end
      end
      COUNT: begin
        // Envelope exit takes priority over timeout and does not count the cycle.
        if (!env_p1) begin
          run_end = 1'b1;
        end else begin
          if (rise) cnt_fin = sat_inc(cnt);
          if (cyc == T_LAST) begin
            run_end  = 1'b1;
            run_tout = 1'b1;
          end
        end
        if (run_end) begin
          state_n = last_run ? DONE : EXCITE;
          cyc_n   = '0;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    cnt_n = (state == COUNT && !run_end) ? cnt_fin : '0;
  end

  // Stage p0/p1: two-flop synchronisers; p2: edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      osc_p0 <= 1'b0;
      osc_p1 <= 1'b0;
      osc_p2 <= 1'b0;
      env_p0 <= 1'b0;
      env_p1 <= 1'b0;
      q_r    <= '0;
      tout_r <= 1'b0;
    end else begin
      state  <= state_n;
      osc_p0 <= bus.osc_in;
      osc_p1 <= osc_p0;
      osc_p2 <= osc_p1;
      env_p0 <= bus.env_above;
      env_p1 <= env_p0;
      // Result is captured on entry to DONE so it is valid alongside ready.
      if (run_end && last_run) begin
        q_r    <= result;
        tout_r <= tout_total;
      end
    end
  end

  always_ff @(posedge clk) begin
    cyc <= cyc_n;
    cnt <= cnt_n;
  end

  assign bus.excite     = (state == EXCITE);
  assign bus.busy       = (state != IDLE);
  assign bus.ready      = (state == DONE);
  assign bus.q_measured = q_r;
  assign bus.timeout    = tout_r;

endmodule

// File: tb/tb_q_ringdown_meter.sv
// Testbench for q_ringdown_meter. Three instances share the resonator stimulus:
//   A: WIDTH=10, TIMEOUT=4096   B: WIDTH=4, TIMEOUT=200   C: WIDTH=10, TIMEOUT=200
// A table of measurements with constant expectations is applied, followed by
// reset/abort sequences and randomized measurements checked against a model
// computed from the recorded input samples.
module tb_q_ringdown_meter;

  localparam int E  = 64;
  localparam int S  = 8;
  localparam int HN = 65536;
`ifdef Q_MEAS_AVG4_EN
  localparam int NRUNS = 4;
`else
  localparam int NRUNS = 1;
`endif

  int TS[3]   = '{4096, 200, 200};
  int MAXV[3] = '{1023, 15, 1023};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic osc = 1'b0;
  logic env = 1'b0;
  logic start_r[3];
  int   half = 4;

  always #5 clk = ~clk;

  q_ringdown_meter_if #(.WIDTH(10)) if_a ();
  q_ringdown_meter_if #(.WIDTH(4))  if_b ();
  q_ringdown_meter_if #(.WIDTH(10)) if_c ();

  q_ringdown_meter #(.WIDTH(10), .EXCITE_CYCLES(E), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(4096))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  q_ringdown_meter #(.WIDTH(4), .EXCITE_CYCLES(E), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(200))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  q_ringdown_meter #(.WIDTH(10), .EXCITE_CYCLES(E), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(200))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.start = start_r[0];
  assign if_b.start = start_r[1];
  assign if_c.start = start_r[2];
  assign if_a.osc_in = osc;
  assign if_b.osc_in = osc;
  assign if_c.osc_in = osc;
  assign if_a.env_above = env;
  assign if_b.env_above = env;
  assign if_c.env_above = env;

  logic       excite_w[3], busy_w[3], ready_w[3], tout_w[3];
  logic [9:0] q_w[3];
  assign excite_w[0] = if_a.excite;
  assign excite_w[1] = if_b.excite;
  assign excite_w[2] = if_c.excite;
  assign busy_w[0]   = if_a.busy;
  assign busy_w[1]   = if_b.busy;
  assign busy_w[2]   = if_c.busy;
  assign ready_w[0]  = if_a.ready;
  assign ready_w[1]  = if_b.ready;
  assign ready_w[2]  = if_c.ready;
  assign tout_w[0]   = if_a.timeout;
  assign tout_w[1]   = if_b.timeout;
  assign tout_w[2]   = if_c.timeout;
  assign q_w[0]      = if_a.q_measured;
  assign q_w[1]      = {6'd0, if_b.q_measured};
  assign q_w[2]      = if_c.q_measured;

  // Input samples as seen by the DUT at each rising edge.
  bit hosc[HN];
  bit henv[HN];
  int ecnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (ecnt < HN) begin
        hosc[ecnt] = osc;
        henv[ecnt] = env;
      end
      ecnt = ecnt + 1;
    end
  end

  // Free-running square wave with programmable half period.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (ph >= half - 1) begin
        ph  = 0;
        osc = ~osc;
      end else begin
        ph = ph + 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: one ring-down per run, counting rising edges of the sampled
  // oscillation while the sampled envelope is high; synchroniser makes the
  // COUNT cycle c see the input sampled at edge c-1.
  function automatic void model(input int d, input int e, output int q, output int t,
                                output int rdy);
    int c0, sum, cnt, endc;
    bit tt, to;
    c0 = e + 1 + E + S;
    sum = 0;
    tt = 1'b0;
    endc = c0;
    for (int r = 0; r < NRUNS; r++) begin
      cnt  = 0;
      endc = c0 + TS[d] - 1;
      to   = 1'b1;
      for (int c = c0; c < c0 + TS[d] && c < HN; c++) begin
        if (!henv[c-1]) begin
          endc = c;
          to   = 1'b0;
          break;
        end
        if (hosc[c-1] && !hosc[c-2] && cnt < MAXV[d]) cnt++;
      end
      sum += cnt;
      tt  |= to;
      c0   = endc + 1 + E + S;
    end
    q   = (NRUNS == 4) ? (sum >> 2) : sum;
    t   = int'(tt);
    rdy = endc + 1;
  endfunction

  int m_e, m_nrdy, m_rdy, m_nexc, m_exc_first, m_busy_after, m_q, m_t;

  task automatic plan(input int d, input int c0, input int len, output int x, output int endc);
    if (len < 0 || len >= TS[d]) begin
      x    = -1000;
      endc = c0 + TS[d] - 1;
    end else begin
      x    = c0 + len - 2;
      endc = c0 + len;
    end
  endtask

  task automatic measure(input int d, input int hp, input int l0, input int l1,
                         input int l2, input int l3, input bit inj);
    int ls[4];
    int c0, endc, x, run, cur, budget;
    ls = '{l0, l1, l2, l3};
    half = hp;
    env  = 1'b1;
    @(negedge clk);
    m_e = ecnt - 1;
    start_r[d] = 1'b1;
    run = 0;
    c0  = m_e + 1 + E + S;
    plan(d, c0, ls[0], x, endc);
    m_nrdy = 0; m_rdy = -1; m_nexc = 0; m_exc_first = -1; m_busy_after = 1;
    m_q = -1; m_t = -1;
    budget = NRUNS * (E + S + TS[d] + 2) + 10;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      cur = ecnt - 1;
      start_r[d] = inj && (cur == m_e + 10 || cur == m_e + 40);
      if (run < NRUNS - 1 && cur == endc + 2) begin
        run++;
        c0  = endc + 1 + E + S;
        plan(d, c0, ls[run], x, endc);
        env = 1'b1;
      end
      if (cur == x) env = 1'b0;
      if (excite_w[d]) begin
        m_nexc++;
        if (m_exc_first < 0) m_exc_first = cur;
      end
      if (ready_w[d]) begin
        m_nrdy++;
        m_rdy = cur;
        m_q   = int'(q_w[d]);
        m_t   = int'(tout_w[d]);
      end
      if (m_rdy >= 0 && cur == m_rdy + 1) m_busy_after = int'(busy_w[d]);
      if (m_rdy >= 0 && cur == m_rdy + 3) break;
    end
    start_r[d] = 1'b0;
  endtask

  task automatic check_vs_model(input string tag, input int d);
    int mq, mt, mr;
    model(d, m_e, mq, mt, mr);
    check({tag, " ready_count"}, m_nrdy, 1);
    check({tag, " q_vs_model"}, m_q, mq);
    check({tag, " timeout_vs_model"}, m_t, mt);
    check({tag, " ready_cycle_vs_model"}, m_rdy, mr);
  endtask

  typedef struct {
    int d;
    int hp;
    int len;
    int exp_q;
    int exp_t;
    int dur;
    bit inj;
  } vec_t;

  vec_t tbl[8];

  initial begin
    string tag;
    int    cur, tgt, nbad_rdy, nbusy, nexc;
    bit    reached;

    tbl[0] = '{d: 0, hp: 4, len: 320, exp_q: 40, exp_t: 0, dur: 321, inj: 1'b1};
    tbl[1] = '{d: 1, hp: 3, len: 150, exp_q: 15, exp_t: 0, dur: 151, inj: 1'b0};
    tbl[2] = '{d: 2, hp: 4, len: -1,  exp_q: 25, exp_t: 1, dur: 200, inj: 1'b0};
    tbl[3] = '{d: 0, hp: 4, len: 0,   exp_q: 0,  exp_t: 0, dur: 1,   inj: 1'b0};
    tbl[4] = '{d: 0, hp: 2, len: 100, exp_q: 25, exp_t: 0, dur: 101, inj: 1'b0};
    tbl[5] = '{d: 2, hp: 4, len: 199, exp_q: -1, exp_t: 0, dur: 200, inj: 1'b0};
    tbl[6] = '{d: 1, hp: 2, len: 60,  exp_q: 15, exp_t: 0, dur: 61,  inj: 1'b0};
    tbl[7] = '{d: 1, hp: 2, len: 56,  exp_q: 14, exp_t: 0, dur: 57,  inj: 1'b0};

    for (int i = 0; i < 3; i++) start_r[i] = 1'b0;

    // Reset: three cycles, then start asserted while still in reset.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outputs_dut%0d", i),
            int'({excite_w[i], busy_w[i], ready_w[i], tout_w[i], q_w[i]}), 0);
    start_r[0] = 1'b1;
    @(negedge clk);
    check("start_in_reset_excite", int'(excite_w[0]), 0);
    rst = 1'b0;
    start_r[0] = 1'b0;
    @(negedge clk);
    check("after_reset_excite", int'(excite_w[0]), 0);
    check("after_reset_busy", int'(busy_w[0]), 0);
    repeat (4) @(negedge clk);

    // Table-driven measurements.
    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("vec%0d", i);
      measure(tbl[i].d, tbl[i].hp, tbl[i].len, tbl[i].len, tbl[i].len, tbl[i].len, tbl[i].inj);
      if (tbl[i].exp_q >= 0) check({tag, " q"}, m_q, tbl[i].exp_q);
      check({tag, " timeout"}, m_t, tbl[i].exp_t);
      check({tag, " ready_offset"}, m_rdy - m_e, 1 + NRUNS * (E + S + tbl[i].dur));
      check({tag, " excite_cycles"}, m_nexc, NRUNS * E);
      check({tag, " excite_first"}, m_exc_first, m_e + 1);
      check({tag, " busy_after_ready"}, m_busy_after, 0);
      check_vs_model(tag, tbl[i].d);
      repeat (3) @(negedge clk);
    end

`ifdef Q_MEAS_AVG4_EN
    // Four runs with counts 40, 41, 42, 44 -> truncated average 41.
    measure(0, 4, 320, 328, 336, 352, 1'b0);
    check("avg4 q", m_q, 41);
    check("avg4 timeout", m_t, 0);
    check_vs_model("avg4", 0);
    repeat (3) @(negedge clk);
`endif

    // Reset during COUNT aborts with no ready.
    half = 4;
    env  = 1'b1;
    @(negedge clk);
    m_e = ecnt - 1;
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    tgt = m_e + 1 + E + S + 20;
    reached = 1'b0;
    for (int k = 0; k < 500; k++) begin
      cur = ecnt - 1;
      if (cur == tgt) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort reached_count", int'(reached), 1);
    check("abort busy_in_count", int'(busy_w[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nbad_rdy = 0; nbusy = 0; nexc = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ready_w[0]) nbad_rdy++;
      if (busy_w[0]) nbusy++;
      if (excite_w[0]) nexc++;
    end
    check("abort ready_pulses", nbad_rdy, 0);
    check("abort busy_cycles", nbusy, 0);
    check("abort excite_cycles", nexc, 0);
    check("abort q_cleared", int'(q_w[0]), 0);

    // Randomized measurements against the model.
    for (int i = 0; i < 6; i++) begin
      int d, hp, len;
      d  = $urandom_range(0, 2);
      hp = $urandom_range(2, 6);
      if (d != 0 && $urandom_range(0, 3) == 0) len = -1;
      else len = $urandom_range(0, 250);
      repeat ($urandom_range(1, 7)) @(negedge clk);
      measure(d, hp, len, len, len, len, 1'b0);
      check_vs_model($sformatf("rand%0d", i), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
